// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the write port of the dual-clock FIFO among
// NUM_REQ producers in the write clock domain. One producer is granted at a
// time for a burst of up to MAX_BURST beats; FIFO back-pressure (wfull) holds
// the grant without counting beats. Arbitration is registered, so every grant
// is preceded by one idle bubble cycle.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int BW        = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_wfull,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic [IDW-1:0]                grant_id,
   output logic                          busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Last grantee after reset is the top index so that requester 0 wins first.
   localparam logic [IDW-1:0] LAST_RST   = IDW'(NUM_REQ - 1);
   localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

   state_t                  state_q,      state_d;
   logic [IDW-1:0]          grant_id_q,   grant_id_d;
   logic [IDW-1:0]          last_grant_q, last_grant_d;
   logic [BW-1:0]           burst_cnt_q,  burst_cnt_d;

   logic                    in_grant_s;
   logic                    gnt_valid_s;
   logic [DATA_WIDTH-1:0]   gnt_data_s;
   logic                    beat_s;

   // First valid requester scanning last+1, last+2, ... modulo NUM_REQ.
   function automatic logic [IDW-1:0] pick_next(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDW-1:0]     last);
      logic [IDW-1:0] sel;
      logic           found;
      int             idx;
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end else begin
            idx = idx;
         end
         if (!found && valid[idx]) begin
            sel   = IDW'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return sel;
   endfunction

   // Select the granted requester's valid and data; only the grantee can reach outputs.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_data_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_valid_s = (grant_id_q == IDW'(i)) ? req_valid[i] : gnt_valid_s;
         gnt_data_s  = (grant_id_q == IDW'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                               : gnt_data_s;
      end
   end

   // FIFO-facing handshake: decoded from registered state, gated by wfull and grantee valid.
   always_comb begin
      in_grant_s = (state_q == ST_GRANT);
      beat_s     = in_grant_s && gnt_valid_s && !fifo_wfull;
      fifo_wr_en = beat_s;
      fifo_wdata = in_grant_s ? gnt_data_s : {DATA_WIDTH{1'b0}};
      req_ready  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = in_grant_s && (grant_id_q == IDW'(i)) && !fifo_wfull;
      end
      busy       = in_grant_s;
      grant_id   = grant_id_q;
   end

   // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               state_d     = ST_GRANT;
               grant_id_d  = pick_next(req_valid, last_grant_q);
               burst_cnt_d = '0;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!gnt_valid_s) begin
               // Grantee withdrew: end the grant without a beat.
               state_d      = ST_IDLE;
               last_grant_d = grant_id_q;
               burst_cnt_d  = '0;
            end else if (beat_s) begin
               if (burst_cnt_q == BURST_LAST) begin
                  state_d      = ST_IDLE;
                  last_grant_d = grant_id_q;
                  burst_cnt_d  = '0;
               end else begin
                  burst_cnt_d  = burst_cnt_q + BW'(1);
               end
            end else begin
               // FIFO full: hold the grant with the beat count frozen.
               state_d = ST_GRANT;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            grant_id_d   = '0;
            last_grant_d = LAST_RST;
            burst_cnt_d  = '0;
         end
      endcase
   end

   // Arbiter state registers with asynchronous active-low reset.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q      <= ST_IDLE;
         grant_id_q   <= '0;
         last_grant_q <= LAST_RST;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter with a behavioural
// reference model (4 requesters, burst 4) plus a directed check of a
// 2-requester, burst-1 instance.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            wclk = 1'b0;
   logic            wrst_n;

   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_wfull;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wdata;
   logic [1:0]      grant_id;
   logic            busy;

   logic [1:0]      b_req_valid;
   logic [15:0]     b_req_data;
   logic [1:0]      b_req_ready;
   logic            b_wfull;
   logic            b_wr_en;
   logic [7:0]      b_wdata;
   logic [0:0]      b_grant_id;
   logic            b_busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit              m_busy;
   int              m_gid;
   int              m_last;
   int              m_beats;
   logic [DW-1:0]   pdata [N];
   int              next_rst;
   int              wr_count;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .wclk       (wclk),
      .wrst_n     (wrst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_wfull (fifo_wfull),
      .fifo_wr_en (fifo_wr_en),
      .fifo_wdata (fifo_wdata),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
      .wclk       (wclk),
      .wrst_n     (wrst_n),
      .req_valid  (b_req_valid),
      .req_data   (b_req_data),
      .req_ready  (b_req_ready),
      .fifo_wfull (b_wfull),
      .fifo_wr_en (b_wr_en),
      .fifo_wdata (b_wdata),
      .grant_id   (b_grant_id),
      .busy       (b_busy)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_gid   = 0;
      m_last  = N - 1;
      m_beats = 0;
   endtask

   // Apply the arbitration rules for one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int idx;
      if (!m_busy) begin
         if (req_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (req_valid[idx]) begin
                  m_gid = idx;
                  break;
               end
            end
            m_busy  = 1'b1;
            m_beats = 0;
         end
      end else if (!req_valid[m_gid]) begin
         m_busy = 1'b0;
         m_last = m_gid;
      end else if (!fifo_wfull) begin
         pdata[m_gid] = DW'($urandom);
         m_beats++;
         if (m_beats == MB) begin
            m_busy = 1'b0;
            m_last = m_gid;
         end
      end
   endtask

   task automatic drive(input bit directed);
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
         req_data[i*DW +: DW]   = pdata[i];
      end
      fifo_wfull = directed ? 1'b0 : ($urandom_range(0, 9) < 3);
   endtask

   task automatic check_main();
      logic [N-1:0]  e_ready;
      logic          e_wr;
      logic [DW-1:0] e_data;
      e_ready = '0;
      if (m_busy && !fifo_wfull) e_ready[m_gid] = 1'b1;
      e_wr   = m_busy && req_valid[m_gid] && !fifo_wfull;
      e_data = m_busy ? pdata[m_gid] : '0;
      check_val("busy",     busy,       m_busy);
      check_val("grant_id", grant_id,   m_gid);
      check_val("ready",    req_ready,  e_ready);
      check_val("wr_en",    fifo_wr_en, e_wr);
      check_val("wdata",    fifo_wdata, e_data);
   endtask

   initial begin
      wrst_n      = 1'b0;
      req_valid   = '0;
      req_data    = '0;
      fifo_wfull  = 1'b0;
      b_req_valid = 2'b11;
      b_req_data  = 16'hB1B0;
      b_wfull     = 1'b0;
      wr_count    = 0;
      next_rst    = 300;
      for (int i = 0; i < N; i++) pdata[i] = DW'($urandom);
      model_reset();

      @(negedge wclk);
      check_main();
      check_val("b_rst_busy", b_busy,     1'b0);
      check_val("b_rst_wr",   b_wr_en,    1'b0);
      check_val("b_rst_gid",  b_grant_id, 1'b0);
      check_val("b_rst_rdy",  b_req_ready, 2'b00);
      @(negedge wclk);
      wrst_n = 1'b1;
      drive(1'b1);

      for (int cyc = 1; cyc <= 1500; cyc++) begin
         @(posedge wclk);
         model_edge();
         #1;
         drive(cyc < 40);
         @(negedge wclk);
         check_main();

         // Directed: with all requesters valid, 5 grants of 4 beats + bubble each.
         if (cyc <= 25 && fifo_wr_en) wr_count++;
         if (cyc == 25) check_val("dir_beats", wr_count, 20);
         if (cyc == 21) check_val("dir_wrap_gid", grant_id, 2'd0);

         // Two-requester, single-beat instance alternates with a bubble between beats.
         if (cyc <= 8) begin
            check_val("b_busy", b_busy,  (cyc % 2) == 1);
            check_val("b_wr",   b_wr_en, (cyc % 2) == 1);
            if (cyc % 2 == 1) begin
               check_val("b_gid",   b_grant_id, ((cyc - 1) / 2) % 2);
               check_val("b_wdata", b_wdata, (((cyc - 1) / 2) % 2) ? 8'hB1 : 8'hB0);
            end
         end

         // Asynchronous reset in the middle of a burst.
         if (cyc >= next_rst && m_busy && m_beats >= 1 && req_valid[m_gid] && !fifo_wfull) begin
            wrst_n = 1'b0;
            #1;
            check_val("arst_wr",   fifo_wr_en, 1'b0);
            check_val("arst_busy", busy,       1'b0);
            check_val("arst_rdy",  req_ready,  4'b0000);
            check_val("arst_gid",  grant_id,   2'd0);
            check_val("arst_data", fifo_wdata, 8'h00);
            #1;
            wrst_n = 1'b1;
            model_reset();
            next_rst += 600;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
